// File: rtl/itu656_encoder.sv
// BT.656 525/60 byte-stream generator and timing master; pixels are requested two bytes ahead of use.
// Registered outputs; no backpressure: a pixel not supplied in time is blanked and flagged as underrun.
module itu656_encoder #(
  parameter int H_ACTIVE = 720,
  parameter int H_BLANK  = 268,
  parameter int V_TOTAL  = 525
) (
  input  logic        iCLK_27,
  input  logic        iRST_N,
  input  logic [15:0] iYC,
  input  logic        iYC_VALID,
  output logic        oREQ,
  output logic [9:0]  oREQ_X,
  output logic [8:0]  oREQ_Y,
  output logic        oFIELD,
  output logic [7:0]  oTD_DATA,
  output logic        oHBLANK,
  output logic        oVBLANK,
  output logic        oUNDERRUN
);

  localparam int LINE_LEN = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int BW       = $clog2(LINE_LEN);

  localparam logic [BW-1:0] B_BLK     = BW'(4);
  localparam logic [BW-1:0] B_SAV     = BW'(4 + H_BLANK);
  localparam logic [BW-1:0] B_REQ0    = BW'(6 + H_BLANK);
  localparam logic [BW-1:0] B_ACT     = BW'(8 + H_BLANK);
  localparam logic [BW-1:0] B_REQ_END = BW'(6 + H_BLANK + 2 * H_ACTIVE);
  localparam logic [BW-1:0] B_LAST    = BW'(LINE_LEN - 1);
  localparam logic [9:0]    L_LAST    = 10'(V_TOTAL);

  // b/l address the byte that the next clock edge puts on oTD_DATA
  logic [BW-1:0] b;
  logic [9:0]    l;
  logic          f, v, in_eav, in_sav, in_act, req_now, c_slot, act_odd;
  logic [1:0]    sav_idx;
  logic [7:0]    y_hold, next_byte;

  function automatic logic [7:0] xy(input logic fb, input logic vb, input logic hb);
    return {1'b1, fb, vb, hb, vb ^ hb, fb ^ hb, fb ^ vb, fb ^ vb ^ hb};
  endfunction

  function automatic logic [7:0] clip(input logic [7:0] d);
    return (d == 8'h00) ? 8'h01 : (d == 8'hFF) ? 8'hFE : d;
  endfunction

  function automatic logic [7:0] tcode(input logic [1:0] idx, input logic [7:0] code);
    case (idx)
      2'd0:    return 8'hFF;
      2'd3:    return code;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    f       = (l <= 10'd3) || (l >= 10'd266);
    v       = (l <= 10'd19) || ((l >= 10'd264) && (l <= 10'd282));
    in_eav  = b < B_BLK;
    in_sav  = (b >= B_SAV) && (b < B_ACT);
    in_act  = b >= B_ACT;
    sav_idx = 2'(b - B_SAV);
    act_odd = b[0] ^ B_ACT[0];
    c_slot  = in_act && !act_odd;
    req_now = !v && (b >= B_REQ0) && (b < B_REQ_END) && (b[0] == B_REQ0[0]);

    next_byte = b[0] ? 8'h10 : 8'h80;
    if (in_eav)
      next_byte = tcode(b[1:0], xy(f, v, 1'b1));
    else if (in_sav)
      next_byte = tcode(sav_idx, xy(f, v, 1'b0));
    else if (in_act && !v)
      next_byte = c_slot ? (iYC_VALID ? clip(iYC[7:0]) : 8'h80) : y_hold;
    else if (in_act)
      next_byte = act_odd ? 8'h10 : 8'h80;
  end

  always_ff @(posedge iCLK_27) begin
    if (!iRST_N) begin
      b         <= '0;
      l         <= 10'd1;
      oTD_DATA  <= 8'h80;
      oREQ      <= 1'b0;
      oREQ_X    <= '0;
      oREQ_Y    <= '0;
      oFIELD    <= 1'b0;
      oHBLANK   <= 1'b1;
      oVBLANK   <= 1'b1;
      oUNDERRUN <= 1'b0;
      y_hold    <= 8'h10;
    end else begin
      oTD_DATA <= next_byte;
      oFIELD   <= f;
      oVBLANK  <= v;
      oHBLANK  <= !in_act;
      oREQ     <= req_now;
      if (req_now) begin
        oREQ_X <= 10'((b - B_REQ0) >> 1);
        oREQ_Y <= f ? 9'(l - 10'd283) : 9'(l - 10'd20);
      end
      // iYC is sampled on the edge that emits the chroma byte; luma follows one byte later
      if (c_slot && !v) begin
        y_hold <= iYC_VALID ? clip(iYC[15:8]) : 8'h10;
        if (!iYC_VALID)
          oUNDERRUN <= 1'b1;
      end
      if (b == B_LAST) begin
        b <= '0;
        l <= (l == L_LAST) ? 10'd1 : l + 10'd1;
      end else begin
        b <= b + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_itu656_encoder.sv
// Directed bench: a full-size encoder covers lines 1-20, a short-line encoder covers the whole frame,
// wrap, underrun, field 1 and mid-frame reset.
module tb_itu656_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] a_yc, b_yc;
  logic        a_yc_vld, b_yc_vld;
  logic        a_req, b_req;
  logic [9:0]  a_req_x, b_req_x;
  logic [8:0]  a_req_y, b_req_y;
  logic        a_field, b_field, a_hblank, b_hblank, a_vblank, b_vblank, a_under, b_under;
  logic [7:0]  a_dat, b_dat;

  int checks = 0;
  int failures = 0;

  itu656_encoder u_a (
    .iCLK_27(clk), .iRST_N(rst_a), .iYC(a_yc), .iYC_VALID(a_yc_vld),
    .oREQ(a_req), .oREQ_X(a_req_x), .oREQ_Y(a_req_y), .oFIELD(a_field),
    .oTD_DATA(a_dat), .oHBLANK(a_hblank), .oVBLANK(a_vblank), .oUNDERRUN(a_under)
  );

  // 32-byte lines: EAV 0-3, blank 4-11, SAV 12-15, active 16-31
  itu656_encoder #(.H_ACTIVE(8), .H_BLANK(8)) u_b (
    .iCLK_27(clk), .iRST_N(rst_b), .iYC(b_yc), .iYC_VALID(b_yc_vld),
    .oREQ(b_req), .oREQ_X(b_req_x), .oREQ_Y(b_req_y), .oFIELD(b_field),
    .oTD_DATA(b_dat), .oHBLANK(b_hblank), .oVBLANK(b_vblank), .oUNDERRUN(b_under)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [9:0] x, input logic [8:0] y);
    logic [7:0] yy, cc;
    yy = 8'h20 + {1'b0, x[6:0]};
    cc = 8'h40 + {1'b0, y[6:0]};
    return {yy, cc};
  endfunction

  // Sources answer a request seen in cycle t by presenting data throughout cycle t+1
  always begin : src_a
    logic pend, pf;
    logic [9:0] px;
    logic [8:0] py;
    @(negedge clk);
    pend = a_req; px = a_req_x; py = a_req_y; pf = a_field;
    @(posedge clk);
    #1;
    a_yc_vld = pend;
    a_yc = pend ? pat(px, py) : 16'h0;
    if (pend && !pf && py == 9'd0 && px == 10'd0) a_yc = 16'h5A33;
    if (pend && !pf && py == 9'd0 && px == 10'd1) a_yc = 16'hFF00;
  end

  always begin : src_b
    logic pend, pf;
    logic [9:0] px;
    logic [8:0] py;
    @(negedge clk);
    pend = b_req; px = b_req_x; py = b_req_y; pf = b_field;
    @(posedge clk);
    #1;
    b_yc_vld = pend;
    b_yc = pend ? pat(px, py) : 16'h0;
    if (pend && !pf && py == 9'd0 && px == 10'd3) b_yc = 16'hFF00;
    if (pend && !pf && py == 9'd0 && px == 10'd4) b_yc = 16'h00FF;
    if (pend && !pf && py == 9'd80 && px == 10'd5) b_yc_vld = 1'b0;
  end

  initial begin
    logic [7:0] eav1[4], sav1[4], eav20[4], sav20[4];
    logic [7:0] ex;
    logic rdone;
    int ca, cb, la, ba, lb, bb, pb, fb, rcnt, a_line_req, a_last_x, a_errs, k;

    eav1  = '{8'hFF, 8'h00, 8'h00, 8'hF1};
    sav1  = '{8'hFF, 8'h00, 8'h00, 8'hEC};
    eav20 = '{8'hFF, 8'h00, 8'h00, 8'h9D};
    sav20 = '{8'hFF, 8'h00, 8'h00, 8'h80};
    rst_a = 1'b0; rst_b = 1'b0;
    a_yc = '0; a_yc_vld = 1'b0; b_yc = '0; b_yc_vld = 1'b0;
    rdone = 1'b0; rcnt = 0; a_line_req = 0; a_last_x = -1; a_errs = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dat", a_dat, 8'h80);
    check("rst_req", a_req, 0);
    check("rst_req_x", a_req_x, 0);
    check("rst_req_y", a_req_y, 0);
    check("rst_field", a_field, 0);
    check("rst_hblank", a_hblank, 1);
    check("rst_vblank", a_vblank, 1);
    check("rst_under", a_under, 0);
    check("rst_b_dat", b_dat, 8'h80);
    rst_a = 1'b1; rst_b = 1'b1;
    ca = -1; cb = -1;

    for (int n = 0; n < 34400; n++) begin
      @(posedge clk);
      #1;
      ca++;
      if (ca < 20 * 1716) begin
        la = ca / 1716 + 1;
        ba = ca % 1716;
        if (la == 1) begin
          if (ba == 0) begin
            check("a_l1_field", a_field, 1);
            check("a_l1_vblank", a_vblank, 1);
            a_line_req = 0;
          end
          if (ba < 4) check($sformatf("a_l1_eav%0d", ba), a_dat, eav1[ba]);
          if (ba == 4) check("a_l1_b4", a_dat, 8'h80);
          if (ba == 5) check("a_l1_b5", a_dat, 8'h10);
          if (ba == 271) check("a_l1_b271", a_dat, 8'h10);
          if (ba >= 272 && ba < 276) check($sformatf("a_l1_sav%0d", ba - 272), a_dat, sav1[ba - 272]);
          if (ba == 300) check("a_l1_vact_b300", a_dat, 8'h80);
          if (ba == 301) check("a_l1_vact_b301", a_dat, 8'h10);
          if (a_req) a_line_req++;
          if (ba == 1715) check("a_l1_req_count", a_line_req, 0);
        end
        if (la == 19 && ba == 0) check("a_l19_vblank", a_vblank, 1);
        if (la == 20) begin
          if (ba == 0) begin
            check("a_l20_vblank", a_vblank, 0);
            check("a_l20_field", a_field, 0);
            a_line_req = 0; a_errs = 0; a_last_x = -1;
          end
          if (ba < 4) check($sformatf("a_l20_eav%0d", ba), a_dat, eav20[ba]);
          if (ba >= 272 && ba < 276) check($sformatf("a_l20_sav%0d", ba - 272), a_dat, sav20[ba - 272]);
          if (a_req) begin
            a_line_req++;
            a_last_x = int'(a_req_x);
          end
          if (ba == 273) check("a_l20_noreq_273", a_req, 0);
          if (ba == 274) begin
            check("a_l20_req0", a_req, 1);
            check("a_l20_req0_x", a_req_x, 0);
            check("a_l20_req0_y", a_req_y, 0);
          end
          if (ba == 275) check("a_l20_hblank_sav", a_hblank, 1);
          if (ba == 276) begin
            check("a_l20_hblank_act", a_hblank, 0);
            check("a_l20_c0", a_dat, 8'h33);
          end
          if (ba == 277) check("a_l20_y0", a_dat, 8'h5A);
          if (ba == 278) check("a_l20_clip_c", a_dat, 8'h01);
          if (ba == 279) check("a_l20_clip_y", a_dat, 8'hFE);
          if (ba >= 280) begin
            k = (ba - 276) / 2;
            ex = (ba % 2 == 0) ? 8'h40 : 8'(32'h20 + (k % 128));
            if (a_dat !== ex) a_errs++;
          end
          if (ba == 1715) begin
            check("a_l20_req_count", a_line_req, 720);
            check("a_l20_last_x", a_last_x, 719);
            check("a_l20_active_errs", a_errs, 0);
            check("a_l20_under", a_under, 0);
          end
        end
      end

      if (rst_b) cb++;
      else cb = -1;
      if (!rst_b) begin
        check("b_rst_dat", b_dat, 8'h80);
        check("b_rst_req", b_req, 0);
        check("b_rst_under", b_under, 0);
        check("b_rst_hblank", b_hblank, 1);
        rcnt++;
        if (rcnt == 3) rst_b = 1'b1;
      end else if (rdone) begin
        if (cb < 4) check($sformatf("b_restart_eav%0d", cb), b_dat, eav1[cb]);
        if (cb == 0) begin
          check("b_restart_under", b_under, 0);
          check("b_restart_field", b_field, 1);
          check("b_restart_vblank", b_vblank, 1);
        end
      end else begin
        fb = cb / 16800;
        pb = cb % 16800;
        lb = pb / 32 + 1;
        bb = pb % 32;
        if (cb >= 16800 && cb < 16804) check($sformatf("b_wrap_eav%0d", cb - 16800), b_dat, eav1[cb - 16800]);
        if (fb == 0) begin
          if (cb < 4) check($sformatf("b_l1_eav%0d", cb), b_dat, eav1[cb]);
          if (lb == 4 && bb == 0) check("b_l4_field", b_field, 0);
          if (lb == 4 && bb == 3) check("b_l4_eav_xy", b_dat, 8'hB6);
          if (lb == 20) begin
            if (bb == 0) check("b_l20_vblank", b_vblank, 0);
            if (bb == 22) check("b_clip_c_00", b_dat, 8'h01);
            if (bb == 23) check("b_clip_y_ff", b_dat, 8'hFE);
            if (bb == 24) check("b_clip_c_ff", b_dat, 8'hFE);
            if (bb == 25) check("b_clip_y_00", b_dat, 8'h01);
          end
          if (lb == 100) begin
            if (bb == 24) begin
              check("b_l100_req", b_req, 1);
              check("b_l100_req_x", b_req_x, 5);
              check("b_l100_req_y", b_req_y, 80);
            end
            if (bb == 25) check("b_l100_under_pre", b_under, 0);
            if (bb == 26) begin
              check("b_l100_under_c", b_dat, 8'h80);
              check("b_l100_under_set", b_under, 1);
            end
            if (bb == 27) check("b_l100_under_y", b_dat, 8'h10);
            if (bb == 28) check("b_l100_next_c", b_dat, 8'h90);
          end
          if (lb == 101 && bb == 0) check("b_l101_under", b_under, 1);
          if (lb == 263 && bb == 0) check("b_l263_vblank", b_vblank, 0);
          if (lb == 264 && bb == 0) check("b_l264_vblank", b_vblank, 1);
          if (lb == 264 && bb == 3) check("b_l264_eav_xy", b_dat, 8'hB6);
          if (lb == 265 && bb == 0) check("b_l265_field", b_field, 0);
          if (lb == 266 && bb == 0) check("b_l266_field", b_field, 1);
          if (lb == 282 && bb == 0) check("b_l282_vblank", b_vblank, 1);
          if (lb == 282 && bb == 3) check("b_l282_eav_xy", b_dat, 8'hF1);
          if (lb == 283) begin
            if (bb == 0) begin
              check("b_l283_field", b_field, 1);
              check("b_l283_vblank", b_vblank, 0);
            end
            if (bb == 3) check("b_l283_eav_xy", b_dat, 8'hDA);
            if (bb == 14) begin
              check("b_l283_req", b_req, 1);
              check("b_l283_req_x", b_req_x, 0);
              check("b_l283_req_y", b_req_y, 0);
            end
            if (bb == 15) check("b_l283_sav_xy", b_dat, 8'hC7);
            if (bb == 16) check("b_l283_c0", b_dat, 8'h40);
            if (bb == 17) check("b_l283_y0", b_dat, 8'h20);
          end
          if (lb == 525) begin
            if (bb == 28) begin
              check("b_l525_req_x", b_req_x, 7);
              check("b_l525_req_y", b_req_y, 242);
            end
            if (bb == 30) check("b_l525_c7", b_dat, 8'hB2);
            if (bb == 31) check("b_l525_y7", b_dat, 8'h27);
          end
        end
        if (fb == 1 && lb == 150 && bb == 20) begin
          check("b_f2_under_sticky", b_under, 1);
          rst_b = 1'b0;
          rdone = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
